// File: rtl/ysyx_22040632_mem_arbiter.sv
// Round-robin arbiter: icache/dcache share one rw memory master, grant held for a whole transaction.
// Latency: one registered cycle from request valid to m_rw_valid; beats and completion are forwarded combinationally; m_rw_ready ends the grant.
module ysyx_22040632_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rrst,

    input  logic                i_rw_valid,
    input  logic                i_rw_req,
    input  logic [ADDR_W-1:0]   i_rw_addr,
    input  logic [LEN_W-1:0]    i_rw_len,
    input  logic [2:0]          i_rw_size,
    output logic                i_rw_ready,
    output logic [DATA_W-1:0]   i_data_read,
    output logic                i_r_hs,
    output logic                i_r_last,

    input  logic                d_rw_valid,
    input  logic                d_rw_req,
    input  logic [ADDR_W-1:0]   d_rw_addr,
    input  logic [LEN_W-1:0]    d_rw_len,
    input  logic [2:0]          d_rw_size,
    input  logic [DATA_W-1:0]   d_data_write,
    input  logic [DATA_W/8-1:0] d_w_strb,
    output logic                d_rw_ready,
    output logic [DATA_W-1:0]   d_data_read,
    output logic                d_r_hs,
    output logic                d_r_last,

    output logic                m_rw_valid,
    output logic                m_rw_req,
    output logic [ADDR_W-1:0]   m_rw_addr,
    output logic [LEN_W-1:0]    m_rw_len,
    output logic [2:0]          m_rw_size,
    output logic [DATA_W-1:0]   m_data_write,
    output logic [DATA_W/8-1:0] m_w_strb,
    input  logic                m_rw_ready,
    input  logic [DATA_W-1:0]   m_data_read,
    input  logic                m_r_hs,
    input  logic                m_r_last,

    output logic [1:0]          grant,
    output logic                beat_err
);

    typedef enum logic [1:0] {S_IDLE, S_GNT_I, S_GNT_D} state_t;

    state_t           r_state;
    state_t           w_nxt_state;
    logic             r_rr_last;
    logic [LEN_W:0]   r_beat_cnt;
    logic [LEN_W-1:0] r_len_q;
    logic             r_wr_q;
    logic             r_beat_err;
    logic [1:0]       r_grant;

    logic             w_sel_i;
    logic             w_sel_d;
    logic             w_enter;
    logic             w_last_bad;
    logic [LEN_W:0]   w_cnt_inc;
    logic [LEN_W:0]   w_len_p1;

    assign w_sel_i = (r_state == S_GNT_I);
    assign w_sel_d = (r_state == S_GNT_D);

    // On completion the other requester goes first so neither can starve the other.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rw_valid && (!d_rw_valid || r_rr_last))
                    w_nxt_state = S_GNT_I;
                else if (d_rw_valid)
                    w_nxt_state = S_GNT_D;
            end
            S_GNT_I: begin
                if (m_rw_ready)
                    w_nxt_state = d_rw_valid ? S_GNT_D : (i_rw_valid ? S_GNT_I : S_IDLE);
            end
            S_GNT_D: begin
                if (m_rw_ready)
                    w_nxt_state = i_rw_valid ? S_GNT_I : (d_rw_valid ? S_GNT_D : S_IDLE);
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    assign w_enter    = (w_nxt_state != S_IDLE) && ((r_state == S_IDLE) || m_rw_ready);
    assign w_cnt_inc  = r_beat_cnt + 1'b1;
    assign w_len_p1   = {1'b0, r_len_q} + 1'b1;
    assign w_last_bad = (w_sel_i || w_sel_d) && !r_wr_q && m_r_hs && m_r_last
                        && (w_cnt_inc != w_len_p1);

    always_ff @(posedge clk) begin
        if (rrst) begin
            r_state    <= S_IDLE;
            r_rr_last  <= 1'b1;
            r_beat_cnt <= '0;
            r_len_q    <= '0;
            r_wr_q     <= 1'b0;
            r_beat_err <= 1'b0;
            r_grant    <= 2'b00;
        end else begin
            r_state    <= w_nxt_state;
            r_grant    <= {w_nxt_state == S_GNT_D, w_nxt_state == S_GNT_I};
            r_beat_err <= w_last_bad;
            if ((r_state != S_IDLE) && m_rw_ready)
                r_rr_last <= w_sel_d;
            if (w_enter) begin
                r_beat_cnt <= '0;
                r_len_q    <= (w_nxt_state == S_GNT_D) ? d_rw_len : i_rw_len;
                r_wr_q     <= (w_nxt_state == S_GNT_D) ? d_rw_req : i_rw_req;
            end else if ((r_state != S_IDLE) && m_r_hs) begin
                r_beat_cnt <= w_cnt_inc;
            end
        end
    end

    always_comb begin
        m_rw_valid   = 1'b0;
        m_rw_req     = 1'b0;
        m_rw_addr    = '0;
        m_rw_len     = '0;
        m_rw_size    = '0;
        m_data_write = '0;
        m_w_strb     = '0;
        if (w_sel_i) begin
            m_rw_valid = i_rw_valid;
            m_rw_req   = i_rw_req;
            m_rw_addr  = i_rw_addr;
            m_rw_len   = i_rw_len;
            m_rw_size  = i_rw_size;
        end else if (w_sel_d) begin
            m_rw_valid   = d_rw_valid;
            m_rw_req     = d_rw_req;
            m_rw_addr    = d_rw_addr;
            m_rw_len     = d_rw_len;
            m_rw_size    = d_rw_size;
            m_data_write = d_data_write;
            m_w_strb     = d_w_strb;
        end
    end

    // Responses reach only the granted side; anything arriving while idle is dropped.
    always_comb begin
        i_rw_ready  = w_sel_i & m_rw_ready;
        i_r_hs      = w_sel_i & m_r_hs;
        i_r_last    = w_sel_i & m_r_last;
        i_data_read = w_sel_i ? m_data_read : '0;
        d_rw_ready  = w_sel_d & m_rw_ready;
        d_r_hs      = w_sel_d & m_r_hs;
        d_r_last    = w_sel_d & m_r_last;
        d_data_read = w_sel_d ? m_data_read : '0;
    end

    assign grant    = r_grant;
    assign beat_err = r_beat_err;

endmodule

// File: doc/ysyx_22040632_mem_arbiter.md
Name: ysyx_22040632_mem_arbiter

Overview:
Two-requester arbiter sharing the single rw-style memory master between icache (port i_) and dcache (port d_). Grant is held for one whole transaction: request → beats → rw_ready completion. Round-robin selection on contention. Data/handshake responses go only to the granted requester. A beat counter flags bursts whose r_last arrives at the wrong beat.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, read/write data width per beat
LEN_W, 8, burst length field width (beats-1)

Ports:
clk  in  1  clock
rrst  in  1  synchronous active-high reset
i_rw_valid / d_rw_valid  in  1  request pending; held high until own rw_ready
i_rw_req / d_rw_req  in  1  0 read, 1 write (i_ always read)
i_rw_addr / d_rw_addr  in  ADDR_W  start address
i_rw_len / d_rw_len  in  LEN_W  beats-1
i_rw_size / d_rw_size  in  3  AXI size code
d_data_write  in  DATA_W  dcache write data
d_w_strb  in  DATA_W/8  dcache byte strobes
i_rw_ready / d_rw_ready  out  1  transaction complete, one-cycle pulse
i_data_read / d_data_read  out  DATA_W  read beat data
i_r_hs / d_r_hs  out  1  read beat valid
i_r_last / d_r_last  out  1  last read beat
m_rw_valid  out  1  downstream request
m_rw_req, m_rw_addr, m_rw_len, m_rw_size, m_data_write, m_w_strb  out  as above  muxed request fields
m_rw_ready, m_data_read, m_r_hs, m_r_last  in  as above  downstream completion/beat signals
grant  out  2  one-hot {d,i}; 00 idle
beat_err  out  1  one-cycle pulse: r_last beat count ≠ len+1

Behaviour:
- State: IDLE, GNT_I, GNT_D. Registers: state, rr_last (last granted: 0=i,1=d), beat_cnt (LEN_W+1 bits), len_q.
- Reset (sync, rrst=1 at clk edge): state=IDLE, rr_last=1 (icache wins first tie), beat_cnt=0, beat_err=0. All outputs 0 while IDLE. Reset mid-burst drops grant immediately; downstream flushing is the memory side's responsibility.
- IDLE: only i_rw_valid → GNT_I; only d_rw_valid → GNT_D; both → requester ≠ rr_last. Grant registered: 1-cycle arbitration latency from valid to m_rw_valid.
- GNT_X: m_rw_* = X fields; m_rw_valid = X_rw_valid. X_data_read/X_r_hs/X_r_last/X_rw_ready = m_* (pass-through, 0 latency). Other requester sees ready/hs/last = 0, data_read = 0.
- Completion: m_rw_ready=1 in GNT_X → rr_last=X; next state: other requester valid → GNT_other (back-to-back, no IDLE bubble); else same requester valid again → GNT_X; else IDLE.
- Grant never changes before m_rw_ready, even if X_rw_valid drops (protocol violation; m_rw_valid follows it low).
- len_q latched from X_rw_len on grant entry. beat_cnt cleared on grant entry, +1 per m_r_hs. On m_r_hs&&m_r_last: beat_err=1 next cycle if beat_cnt+1 ≠ len_q+1. Write transactions: beat_cnt unused, beat_err never asserted.
- m_r_hs/m_r_last/m_rw_ready while IDLE: ignored, not forwarded.
- grant output = registered one-hot of state.

Test Plan:
- Reset then i_rw_valid=1, addr 0x8000_0040, len 7 → grant=01 next cycle; 8 m_r_hs beats forwarded to i_, i_r_last on beat 8, i_rw_ready pulse, d_ outputs stay 0, beat_err=0.
- Both valid same cycle after reset → icache granted first; on its m_rw_ready, next cycle grant=10 (no IDLE cycle); then d_ write len 0 completes, grant=00.
- Sustained contention for 4 transactions → grants alternate i,d,i,d.
- d_ read len 3, memory asserts m_r_last on beat 2 → beat_err pulses 1 cycle after that beat; grant held until m_rw_ready.
- rrst=1 for one cycle during beat 4 of an icache burst → grant=00, all i_ outputs 0 next cycle; subsequent d_ request granted with 1-cycle latency.
- i_ uncacheable read len 0 size 4B → m_rw_len=0, m_rw_size=2, single beat forwarded, i_rw_ready once.
